hex_display_sched: RTL and testbench
====================================

# hex_display_sched

Arbitrates ownership of the board's five 7-segment digits and ten LEDs between the Nios II PIO exports (CPU requester) and a hardware debug/status requester. It uses a request/grant handshake, a minimum ownership hold to prevent flicker, and a CPU force override driven from a switch. It sits between the Nios II system outputs and the top-level HEX/LED pins, and registers all pin outputs.

## Interface
- HOLD_CYCLES, 50_000_000, minimum cycles an owner keeps the display after any ownership change; legal range ≥1 (1 = no hold)
- BLINK_CYCLES, 12_500_000, half-period in cycles of the debug-owner LED blink; legal range ≥1
- clk_clk  in  1  system clock
- reset_reset  in  1  reset, synchronous, active-high
- cpu_hex_in  in  35  CPU segment data; [7k+6:7k] = digit k, active-low
- cpu_led_in  in  10  CPU LED data
- dbg_req  in  1  debug requester asks for the display (level)
- dbg_hex_in  in  35  debug segment data, same packing as cpu_hex_in
- dbg_led_in  in  10  debug LED data
- force_cpu  in  1  CPU override; preempts debug immediately
- dbg_gnt  out  1  debug requester currently owns the display (registered)
- owner  out  1  0 = CPU, 1 = debug (registered; equals dbg_gnt)
- hex0..hex4  out  7 each  segment pins, active-low, digit k from bits [7k+6:7k]
- led  out  10  LED pins

## Operation
- Two states: S_CPU (reset state) and S_DBG. A hold counter hold_cnt is $clog2(HOLD_CYCLES+1) bits wide, decrements by 1 per cycle while nonzero, and saturates at 0.
- S_CPU → S_DBG when dbg_req=1, force_cpu=0 and hold_cnt==0. hold_cnt loads HOLD_CYCLES-1.
- S_DBG → S_CPU when force_cpu=1, regardless of hold_cnt (preemption). hold_cnt loads HOLD_CYCLES-1.
- S_DBG → S_CPU when dbg_req=0 and hold_cnt==0. hold_cnt loads HOLD_CYCLES-1, which gives the CPU a minimum hold as well.
- If dbg_req drops while hold_cnt>0, the block stays in S_DBG and keeps displaying the live dbg inputs until the hold expires.
- Simultaneous events:
  - force_cpu=1 always wins over dbg_req.
  - A dbg_req rising in S_CPU while hold_cnt>0 waits. Grant follows in the cycle hold_cnt reaches 0, provided dbg_req is still 1.
- Output mux selects on the current state register. hexN and led are registered copies of the selected source.
- Reset values:
  - state = S_CPU, hold_cnt = 0, dbg_gnt = 0, owner = 0.
  - hex0..hex4 = 7'h7F (all segments off).
  - led = 10'h000.
  - Blink counter = 0, blink bit = 1.
- Reset asserted mid-operation (any state, any counter value) returns all of the above values on the next clock edge. The first post-reset cycle with reset low behaves as S_CPU with hold_cnt=0.

## Timing
- Latency from input to pin is one cycle: a change on the selected source's hex/led input appears on the pins at the next rising edge.
- dbg_gnt rises on the edge the state register enters S_DBG. Pins show dbg data starting from that same edge's registered output of the following cycle, i.e. one cycle after dbg_gnt rises.
- Release: dbg_gnt falls on the edge S_CPU is entered. Pins show CPU data one cycle later.
- From dbg_req↑ in S_CPU with hold_cnt==0 to dbg_gnt↑ is one edge.
- From force_cpu↑ to dbg_gnt↓ is one edge, and to CPU data on the pins is two edges.
- Minimum spacing between owner changes is HOLD_CYCLES cycles, except for force preemption.

## Configuration
- HEX_SCHED_BLINK_EN defined: in S_DBG, led[9] is overridden by the blink bit.
  - The blink bit starts at 1 on S_DBG entry.
  - It toggles every BLINK_CYCLES cycles, giving a period of 2×BLINK_CYCLES.
  - The counter is cleared whenever the state is S_CPU.
  - led[8:0] = dbg_led_in[8:0].
- HEX_SCHED_BLINK_EN undefined: no blink logic; in S_DBG, led = dbg_led_in unmodified.
- In S_CPU, led = cpu_led_in in both builds.

## Test plan
All scenarios use HOLD_CYCLES=4 and BLINK_CYCLES=3.
- Reset held 2 cycles with random inputs → hex0..4 = 7'h7F, led = 0, dbg_gnt = 0. Then cpu_hex_in = 35'h0, cpu_led_in = 10'h3FF → pins show that CPU data one cycle after reset deasserts.
- dbg_req↑ with hold expired → dbg_gnt=1 at the next edge. hex0 = dbg_hex_in[6:0] (e.g. 7'h40) one cycle later.
- dbg_req pulsed high for 1 cycle → dbg_gnt stays 1 for exactly 4 cycles, then falls. A new dbg_req asserted immediately after is not granted for 4 cycles.
- force_cpu↑ while in S_DBG with hold_cnt=3 → dbg_gnt=0 at the next edge, CPU data on the pins the edge after. dbg_req and force_cpu both high → never granted.
- Blink build, dbg owner for 12 cycles with dbg_led_in = 0 → led[9] pattern 1,1,1,0,0,0,1,1,1,0,0,0. Non-blink build → led[9] = 0 throughout.
- Reset asserted while in S_DBG with hold_cnt=2 → next edge: dbg_gnt=0, pins blank. dbg_req still high after reset → grant on the first edge after reset deasserts.

Source files
------------

// File: rtl/hex_display_sched.sv
// hex_display_sched: arbitrates the five 7-segment digits and ten LEDs between
// the Nios II PIO exports (CPU) and a hardware debug/status requester.
// Ownership changes are rate-limited by a hold counter; force_cpu preempts.
// All pin outputs are registered.
// Optional build macro: HEX_SCHED_BLINK_EN blinks led[9] while debug owns the pins.
module hex_display_sched #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [34:0] cpu_hex_in,
  input  logic [9:0]  cpu_led_in,
  input  logic        dbg_req,
  input  logic [34:0] dbg_hex_in,
  input  logic [9:0]  dbg_led_in,
  input  logic        force_cpu,
  output logic        dbg_gnt,
  output logic        owner,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [9:0]  led
);

  localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  // Both periods must be at least one cycle; catch bad overrides at elaboration.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("hex_display_sched: HOLD_CYCLES must be >= 1");
  end
  if (BLINK_CYCLES < 1) begin : g_bad_blink
    $error("hex_display_sched: BLINK_CYCLES must be >= 1");
  end

  typedef enum logic {
    S_CPU = 1'b0,
    S_DBG = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [34:0]       hex_q, hexSel;
  logic [9:0]        led_q, ledSel;

`ifdef HEX_SCHED_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES < 2) ? 1 : $clog2(BLINK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic               blinkBit_q, blinkBit_d;

  // Blink phase: held cleared (bit on) while the CPU owns, toggles every BLINK_CYCLES in S_DBG.
  always_comb begin
    blinkCnt_d = '0;
    blinkBit_d = 1'b1;
    if (state_q == S_DBG) begin
      if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_d = '0;
        blinkBit_d = ~blinkBit_q;
      end else begin
        blinkCnt_d = blinkCnt_q + BLINK_W'(1);
        blinkBit_d = blinkBit_q;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      blinkCnt_q <= '0;
      blinkBit_q <= 1'b1;
    end else begin
      blinkCnt_q <= blinkCnt_d;
      blinkBit_q <= blinkBit_d;
    end
  end
`endif

  // Ownership FSM: the hold counter gates voluntary changes, force_cpu bypasses it.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = (holdCnt_q != '0) ? holdCnt_q - HOLD_W'(1) : '0;
    case (state_q)
      S_CPU: begin
        if (dbg_req && !force_cpu && (holdCnt_q == '0)) begin
          state_d   = S_DBG;
          holdCnt_d = HOLD_LOAD;
        end
      end
      S_DBG: begin
        if (force_cpu || (!dbg_req && (holdCnt_q == '0))) begin
          state_d   = S_CPU;
          holdCnt_d = HOLD_LOAD;
        end
      end
      default: begin
        state_d   = S_CPU;
        holdCnt_d = '0;
      end
    endcase
  end

  // Pin source mux driven by the registered owner, so pins trail dbg_gnt by a cycle.
  always_comb begin
    hexSel = cpu_hex_in;
    ledSel = cpu_led_in;
    if (state_q == S_DBG) begin
      hexSel = dbg_hex_in;
      ledSel = dbg_led_in;
`ifdef HEX_SCHED_BLINK_EN
      ledSel[9] = blinkBit_q;
`endif
    end
  end

  // State, hold counter and pin registers; reset blanks the display.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= S_CPU;
      holdCnt_q <= '0;
      hex_q     <= {35{1'b1}};
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      hex_q     <= hexSel;
      led_q     <= ledSel;
    end
  end

  assign dbg_gnt = (state_q == S_DBG);
  assign owner   = (state_q == S_DBG);
  assign hex0    = hex_q[6:0];
  assign hex1    = hex_q[13:7];
  assign hex2    = hex_q[20:14];
  assign hex3    = hex_q[27:21];
  assign hex4    = hex_q[34:28];
  assign led     = led_q;

endmodule

// File: tb/tb_hex_display_sched.sv
// tb_hex_display_sched: directed, table-driven bench for hex_display_sched
// with HOLD_CYCLES=4 and BLINK_CYCLES=3. Expected led[9] blink values follow
// the HEX_SCHED_BLINK_EN macro of the build.
module tb_hex_display_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [34:0] cpuHex = '0;
  logic [9:0]  cpuLed = '0;
  logic        dbgReq = 1'b0;
  logic [34:0] dbgHex = '0;
  logic [9:0]  dbgLed = '0;
  logic        forceCpu = 1'b0;
  logic        dbgGnt, ownerOut;
  logic [6:0]  h0, h1, h2, h3, h4;
  logic [9:0]  ledOut;

  int checks = 0;
  int errors = 0;

  localparam logic [34:0] BLANK = {35{1'b1}};
  localparam logic [34:0] RH  = 35'h5_5555_5555;
  localparam logic [34:0] C0  = 35'h0;
  localparam logic [34:0] C1  = 35'h2_4681_3579;
  localparam logic [34:0] DH  = 35'h7_1234_5640;
  localparam logic [34:0] DH2 = 35'h0_0ABC_DE7F;

  typedef struct {
    logic        rst;
    logic        req;
    logic        frc;
    logic [34:0] cpuHex;
    logic [9:0]  cpuLed;
    logic [34:0] dbgHex;
    logic [9:0]  dbgLed;
    logic        expGnt;
    logic [34:0] expHex;
    logic [9:0]  expLed;
  } vec_t;

  vec_t vecs[23];

  hex_display_sched #(.HOLD_CYCLES(4), .BLINK_CYCLES(3)) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .cpu_hex_in (cpuHex),
    .cpu_led_in (cpuLed),
    .dbg_req    (dbgReq),
    .dbg_hex_in (dbgHex),
    .dbg_led_in (dbgLed),
    .force_cpu  (forceCpu),
    .dbg_gnt    (dbgGnt),
    .owner      (ownerOut),
    .hex0       (h0),
    .hex1       (h1),
    .hex2       (h2),
    .hex3       (h3),
    .hex4       (h4),
    .led        (ledOut)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    dbgReq   = v.req;
    forceCpu = v.frc;
    cpuHex   = v.cpuHex;
    cpuLed   = v.cpuLed;
    dbgHex   = v.dbgHex;
    dbgLed   = v.dbgLed;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [34:0] actual, input logic [34:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkPins(input string tag, input logic expGnt, input logic [34:0] expHex, input logic [9:0] expLed);
    checkOutput({tag, ".dbg_gnt"}, 35'(dbgGnt), 35'(expGnt));
    checkOutput({tag, ".owner"}, 35'(ownerOut), 35'(expGnt));
    checkOutput({tag, ".hex"}, {h4, h3, h2, h1, h0}, expHex);
    checkOutput({tag, ".led"}, 35'(ledOut), 35'(expLed));
  endtask

  initial begin
    logic [11:0] blinkExp;

    //        rst  req  frc  cpuHex cpuLed  dbgHex dbgLed   gnt expHex expLed
    vecs[0]  = '{1'b1, 1'b1, 1'b0, RH, 10'h2AA, DH,  10'h155, 1'b0, BLANK, 10'h000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, C1, 10'h0F0, DH2, 10'h3FF, 1'b0, BLANK, 10'h000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, C0, 10'h3FF, DH,  10'h255, 1'b0, C0,    10'h3FF};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, C0, 10'h3FF, DH,  10'h255, 1'b1, C0,    10'h3FF};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, C0, 10'h3FF, DH,  10'h255, 1'b1, DH,    10'h255};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, C0, 10'h3FF, DH2, 10'h255, 1'b1, DH2,   10'h255};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, C0, 10'h3FF, DH2, 10'h255, 1'b1, DH2,   10'h255};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, C0, 10'h3FF, DH2, 10'h055, 1'b0, DH2,   10'h055};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, C1, 10'h0F0, DH2, 10'h055, 1'b0, C1,    10'h0F0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, C1, 10'h0F0, DH,  10'h255, 1'b0, C1,    10'h0F0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, C1, 10'h0F0, DH,  10'h255, 1'b0, C1,    10'h0F0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, C1, 10'h0F0, DH,  10'h255, 1'b1, C1,    10'h0F0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, C1, 10'h0F0, DH,  10'h255, 1'b0, DH,    10'h255};
    vecs[13] = '{1'b0, 1'b1, 1'b1, C1, 10'h0F0, DH,  10'h255, 1'b0, C1,    10'h0F0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, C1, 10'h0F0, DH,  10'h255, 1'b0, C1,    10'h0F0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, C1, 10'h0F0, DH,  10'h255, 1'b0, C1,    10'h0F0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, C1, 10'h0F0, DH,  10'h255, 1'b0, C1,    10'h0F0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, C1, 10'h0F0, DH,  10'h255, 1'b0, C1,    10'h0F0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, C1, 10'h0F0, DH,  10'h255, 1'b1, C1,    10'h0F0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, C1, 10'h0F0, DH,  10'h255, 1'b1, DH,    10'h255};
    vecs[20] = '{1'b1, 1'b1, 1'b0, C1, 10'h0F0, DH,  10'h255, 1'b0, BLANK, 10'h000};
    vecs[21] = '{1'b0, 1'b1, 1'b0, C1, 10'h0F0, DH,  10'h255, 1'b1, C1,    10'h0F0};
    vecs[22] = '{1'b0, 1'b0, 1'b0, C1, 10'h0F0, DH,  10'h255, 1'b1, DH,    10'h255};

`ifdef HEX_SCHED_BLINK_EN
    blinkExp = 12'b000111000111;
`else
    blinkExp = 12'b000000000000;
`endif

    // Table: reset, CPU pass-through, grant, hold, release, force, mid-DBG reset.
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      stepClock();
      checkPins($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expHex, vecs[i].expLed);
    end

    // Clean start for the pulse sequence.
    rst = 1'b1; dbgReq = 1'b0; forceCpu = 1'b0;
    dbgHex = DH; dbgLed = 10'h000;
    stepClock();
    checkPins("preReset", 1'b0, BLANK, 10'h000);
    rst = 1'b0;

    // One-cycle dbg_req pulse: grant held for exactly HOLD_CYCLES cycles.
    dbgReq = 1'b1;
    stepClock();
    checkOutput("pulse.grant", 35'(dbgGnt), 35'd1);
    dbgReq = 1'b0;
    for (int i = 1; i < 4; i++) begin
      stepClock();
      checkOutput($sformatf("pulse.hold%0d", i), 35'(dbgGnt), 35'd1);
    end
    stepClock();
    checkOutput("pulse.release", 35'(dbgGnt), 35'd0);

    // Immediate re-request waits out the CPU hold.
    dbgReq = 1'b1;
    for (int i = 1; i < 4; i++) begin
      stepClock();
      checkOutput($sformatf("rereq.wait%0d", i), 35'(dbgGnt), 35'd0);
    end
    stepClock();
    checkOutput("rereq.grant", 35'(dbgGnt), 35'd1);

    // Twelve debug-owned cycles with dbg_led_in = 0: observe led[9] blink.
    for (int i = 0; i < 12; i++) begin
      stepClock();
      checkOutput($sformatf("blink%0d.led9", i), 35'(ledOut[9]), 35'(blinkExp[i]));
      checkOutput($sformatf("blink%0d.led_lo", i), 35'(ledOut[8:0]), 35'd0);
      checkOutput($sformatf("blink%0d.hex0", i), 35'(h0), 35'h40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
